// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for a Mini SRC subset.
// Walks the fetch cycle (T0..T2), decodes IR[31:27] in T3 and steps the
// execute states T3..T6 one per clock, driving the datapath control lines.
// Optional feature macro: JAL_EN (jump-and-link support). When it is
// undefined, opcode 10100 behaves as nop and R15in stays 0.
`timescale 1ns/1ps

module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        conOut,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        Cout,
  output logic        MARin,
  output logic        Zlowin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        IncPC,
  output logic        Read,
  output logic        conInput,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R15in,
  output logic [3:0]  ctrl,
  output logic        Run
);

  localparam int OPC_HI = 31;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HALT = 5'b11010;
`ifdef JAL_EN
  localparam logic [4:0] OP_JAL  = 5'b10100;
`endif

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state, next_state;

  logic [4:0] opcode;
  logic       is_r, is_i, is_alu, is_br, is_jr, is_jal, is_halt;
  logic       unused_ir;

  // Only the opcode field steers sequencing; register fields are decoded
  // by the datapath itself through Gra/Grb/Grc.
  assign opcode    = IR[OPC_HI -: 5];
  assign unused_ir = ^IR[OPC_HI-5:0];

  assign is_r    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_i    = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                   (opcode == OP_ORI);
  assign is_alu  = is_r || is_i;
  assign is_br   = (opcode == OP_BR);
  assign is_jr   = (opcode == OP_JR);
  assign is_halt = (opcode == OP_HALT);
`ifdef JAL_EN
  assign is_jal  = (opcode == OP_JAL);
`else
  assign is_jal  = 1'b0;
`endif

  // Maps an ALU-class opcode to the ALU ctrl encoding.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: alu_code = ALU_ADD;
      OP_SUB:          alu_code = ALU_SUB;
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_OR,  OP_ORI:  alu_code = ALU_OR;
      default:         alu_code = ALU_ADD;
    endcase
  endfunction

  // State register; Clear asynchronously parks the sequencer in RST.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= S_RST;
    else       state <= next_state;
  end

  // Next-state and Moore output decode (T6 PCin also follows conOut).
  always_comb begin
    next_state = state;
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Rout = 1'b0; Cout = 1'b0;
    MARin = 1'b0; Zlowin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Rin = 1'b0; IncPC = 1'b0; Read = 1'b0; conInput = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R15in = 1'b0;
    ctrl = 4'd0;
    Run  = 1'b1;
    case (state)
      S_RST: begin
        Run        = 1'b0;
        next_state = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        if (is_alu) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
          next_state = S_T4;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; conInput = 1'b1;
          next_state = S_T4;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          next_state = S_T0;
        end else if (is_jal) begin
          PCout = 1'b1;
`ifdef JAL_EN
          R15in = 1'b1;
`endif
          next_state = S_T4;
        end else if (is_halt) begin
          next_state = S_HALT;
        end else begin
          next_state = S_T0;
        end
      end
      S_T4: begin
        next_state = S_T5;
        if (is_r) begin
          Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1;
          ctrl = alu_code(opcode);
        end else if (is_i) begin
          Cout = 1'b1; Zlowin = 1'b1;
          ctrl = alu_code(opcode);
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
`ifdef JAL_EN
        else if (is_jal) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          next_state = S_T0;
        end
`endif
      end
      S_T5: begin
        if (is_alu) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          next_state = S_T0;
        end else if (is_br) begin
          Cout = 1'b1; Zlowin = 1'b1; ctrl = ALU_ADD;
          next_state = S_T6;
        end else begin
          next_state = S_T0;
        end
      end
      S_T6: begin
        Zlowout = 1'b1;
        PCin    = conOut;
        next_state = S_T0;
      end
      S_HALT: begin
        Run        = 1'b0;
        next_state = S_HALT;
      end
      default: begin
        Run        = 1'b0;
        next_state = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit.
// Outputs are packed into one vector and compared per T-state against
// hand-built expectations, sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_control_unit;

  logic        Clock, Clear, conOut;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, Rout, Cout, MARin, Zlowin, PCin, MDRin, IRin;
  logic Yin, Rin, IncPC, Read, conInput, Gra, Grb, Grc, R15in, Run;
  logic [3:0] ctrl;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .conOut(conOut),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
    .Cout(Cout), .MARin(MARin), .Zlowin(Zlowin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .IncPC(IncPC),
    .Read(Read), .conInput(conInput), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .R15in(R15in), .ctrl(ctrl), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [19:0] obs;
  assign obs = {PCout, Zlowout, MDRout, Rout, Cout, MARin, Zlowin, PCin,
                MDRin, IRin, Yin, Rin, IncPC, Read, conInput, Gra, Grb, Grc,
                R15in, Run};

  localparam logic [19:0] M_PCOUT   = 20'h80000;
  localparam logic [19:0] M_ZLOWOUT = 20'h40000;
  localparam logic [19:0] M_MDROUT  = 20'h20000;
  localparam logic [19:0] M_ROUT    = 20'h10000;
  localparam logic [19:0] M_COUT    = 20'h08000;
  localparam logic [19:0] M_MARIN   = 20'h04000;
  localparam logic [19:0] M_ZLOWIN  = 20'h02000;
  localparam logic [19:0] M_PCIN    = 20'h01000;
  localparam logic [19:0] M_MDRIN   = 20'h00800;
  localparam logic [19:0] M_IRIN    = 20'h00400;
  localparam logic [19:0] M_YIN     = 20'h00200;
  localparam logic [19:0] M_RIN     = 20'h00100;
  localparam logic [19:0] M_INCPC   = 20'h00080;
  localparam logic [19:0] M_READ    = 20'h00040;
  localparam logic [19:0] M_CONIN   = 20'h00020;
  localparam logic [19:0] M_GRA     = 20'h00010;
  localparam logic [19:0] M_GRB     = 20'h00008;
  localparam logic [19:0] M_GRC     = 20'h00004;
  localparam logic [19:0] M_R15IN   = 20'h00002;
  localparam logic [19:0] M_RUN     = 20'h00001;

  localparam logic [19:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN;
  localparam logic [19:0] V_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [19:0] V_T2 = M_MDROUT | M_IRIN | M_RUN;

  // Reset state, then release into the first fetch.
  task automatic test_reset;
    Clear = 1'b1; IR = 32'h0; conOut = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h0 || ctrl !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got %h ctrl %0d, want 00000 ctrl 0", obs, ctrl);
    end
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if (obs !== 20'h0 || ctrl !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h ctrl %0d, want 00000 ctrl 0", obs, ctrl);
    end
    @(negedge Clock);
    Clear = 1'b0;
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_rst_state: got %h, want 00000", obs);
    end
    @(negedge Clock);
    checks++;
    if (obs !== V_T0) begin
      errors++;
      $display("FAIL reset_first_t0: got %h, want %h", obs, V_T0);
    end
  endtask

  // R-type and I-type ALU instructions, each run back to back.
  task automatic test_alu_ops;
    logic [31:0] irs [7];
    logic [3:0]  ops [7];
    logic        imm [7];
    logic [19:0] ev  [7];
    logic [3:0]  ec  [7];
    irs = '{32'h18918000, 32'h20000000, 32'h48000000, 32'h50000000,
            32'h58000000, 32'h60000000, 32'h68000000};
    ops = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    imm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      IR = irs[k];
      ev = '{V_T0, V_T1, V_T2,
             M_GRB | M_ROUT | M_YIN | M_RUN,
             imm[k] ? (M_COUT | M_ZLOWIN | M_RUN) : (M_GRC | M_ROUT | M_ZLOWIN | M_RUN),
             M_ZLOWOUT | M_GRA | M_RIN | M_RUN,
             V_T0};
      ec = '{4'd0, 4'd0, 4'd0, 4'd0, ops[k], 4'd0, 4'd0};
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (obs !== ev[i] || ctrl !== ec[i]) begin
          errors++;
          $display("FAIL alu ir=%h step %0d: got %h ctrl %0d, want %h ctrl %0d",
                   irs[k], i, obs, ctrl, ev[i], ec[i]);
        end
        if (i < 6) @(negedge Clock);
      end
    end
  endtask

  // br taken and not taken, plus conOut changing inside T6.
  task automatic test_branch;
    logic [19:0] ev [8];
    logic [3:0]  ec [8];
    logic        c;
    for (int k = 0; k < 2; k++) begin
      c = (k == 0);
      IR = 32'h90000000;
      conOut = c;
      ev = '{V_T0, V_T1, V_T2,
             M_GRA | M_ROUT | M_CONIN | M_RUN,
             M_PCOUT | M_YIN | M_RUN,
             M_COUT | M_ZLOWIN | M_RUN,
             M_ZLOWOUT | M_RUN | (c ? M_PCIN : 20'h0),
             V_T0};
      ec = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0};
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs !== ev[i] || ctrl !== ec[i]) begin
          errors++;
          $display("FAIL branch con=%0b step %0d: got %h ctrl %0d, want %h ctrl %0d",
                   c, i, obs, ctrl, ev[i], ec[i]);
        end
        if (i == 6) begin
          conOut = ~c;
          #1;
          checks++;
          if (PCin !== ~c) begin
            errors++;
            $display("FAIL branch_t6_con_follow: got PCin %b, want %b", PCin, ~c);
          end
        end
        if (i < 7) @(negedge Clock);
      end
    end
    conOut = 1'b0;
  endtask

  // jr, nop, unassigned opcode and jal sequencing.
  task automatic test_jumps;
    logic [31:0] irs [4];
    logic [19:0] ev  [6];
    int          n;
    irs = '{32'h98000000, 32'hC8000000, 32'h00000000, 32'hA0000000};
    for (int k = 0; k < 4; k++) begin
      IR = irs[k];
      ev = '{V_T0, V_T1, V_T2, M_RUN, V_T0, V_T0};
      n = 5;
      if (k == 0) ev[3] = M_GRA | M_ROUT | M_PCIN | M_RUN;
`ifdef JAL_EN
      if (k == 3) begin
        ev[3] = M_PCOUT | M_R15IN | M_RUN;
        ev[4] = M_GRA | M_ROUT | M_PCIN | M_RUN;
        n = 6;
      end
`endif
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs !== ev[i] || ctrl !== 4'd0) begin
          errors++;
          $display("FAIL jump ir=%h step %0d: got %h ctrl %0d, want %h ctrl 0",
                   irs[k], i, obs, ctrl, ev[i]);
        end
        if (i < n - 1) @(negedge Clock);
      end
    end
  endtask

  // halt parks the sequencer with everything low until Clear.
  task automatic test_halt;
    logic [19:0] ev [4];
    IR = 32'hD0000000;
    ev = '{V_T0, V_T1, V_T2, M_RUN};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ev[i] || ctrl !== 4'd0) begin
        errors++;
        $display("FAIL halt_fetch step %0d: got %h ctrl %0d, want %h ctrl 0",
                 i, obs, ctrl, ev[i]);
      end
      @(negedge Clock);
    end
    IR = 32'h18918000;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (obs !== 20'h0 || ctrl !== 4'd0) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %h ctrl %0d, want 00000 ctrl 0",
                 i, obs, ctrl);
      end
      @(negedge Clock);
    end
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    @(negedge Clock);
    checks++;
    if (obs !== V_T0) begin
      errors++;
      $display("FAIL halt_exit: got %h, want %h", obs, V_T0);
    end
  endtask

  // Clear asserted in the middle of T4 of an add.
  task automatic test_clear_mid;
    IR = 32'h18918000;
    repeat (4) @(negedge Clock);
    checks++;
    if (obs !== (M_GRC | M_ROUT | M_ZLOWIN | M_RUN) || ctrl !== 4'd2) begin
      errors++;
      $display("FAIL clear_mid_t4: got %h ctrl %0d, want %h ctrl 2",
               obs, ctrl, M_GRC | M_ROUT | M_ZLOWIN | M_RUN);
    end
    #1 Clear = 1'b1;
    #1;
    checks++;
    if (obs !== 20'h0 || ctrl !== 4'd0) begin
      errors++;
      $display("FAIL clear_mid_async: got %h ctrl %0d, want 00000 ctrl 0", obs, ctrl);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (obs !== 20'h0 || ctrl !== 4'd0) begin
      errors++;
      $display("FAIL clear_mid_hold: got %h ctrl %0d, want 00000 ctrl 0", obs, ctrl);
    end
    @(negedge Clock);
    Clear = 1'b0;
    @(negedge Clock);
    checks++;
    if (obs !== V_T0) begin
      errors++;
      $display("FAIL clear_mid_restart: got %h, want %h", obs, V_T0);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_jumps();
    test_halt();
    test_clear_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
